// File: rtl/fir_coeff_ctrl.sv
// Coefficient bank and sequencing controller for the folded FIR datapath:
// strobe generation, shadow/active coefficient banks, strobe-aligned swap and flush tracking.
module fir_coeff_ctrl #(
    parameter int WIDTH    = 18,
    parameter int NUM_COEF = 8,
    parameter int AW       = 4,
    parameter int CLK_DIV  = 4,
    parameter int FLUSH    = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      coef_wr_valid,
    output logic                      coef_wr_ready,
    input  logic [AW-1:0]             coef_wr_addr,
    input  logic [WIDTH-1:0]          coef_wr_data,
    input  logic                      commit,
    output logic                      sys_clk2_en,
    output logic [NUM_COEF*WIDTH-1:0] coef_bus,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      swap_done,
    output logic                      wr_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]                           state;
    logic [CW-1:0]                        div_cnt;
    logic [FW-1:0]                        flush_cnt;
    logic [NUM_COEF-1:0][WIDTH-1:0]       shadow;
    logic [NUM_COEF-1:0][WIDTH-1:0]       active;
    logic                                 wr_acc;
    logic                                 addr_bad;

    assign coef_wr_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign wr_acc        = coef_wr_valid && coef_wr_ready;
    assign addr_bad      = (coef_wr_addr >= AW'(NUM_COEF));
    assign coef_bus      = active;

    // Free-running divider; the strobe is registered off the wrap so it is glitch-free.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            sys_clk2_en <= 1'b0;
        end else if (div_cnt == CW'(CLK_DIV - 1)) begin
            div_cnt     <= '0;
            sys_clk2_en <= 1'b1;
        end else begin
            div_cnt     <= div_cnt + CW'(1);
            sys_clk2_en <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_acc && addr_bad;
            for (int k = 0; k < NUM_COEF; k++) begin
                if (wr_acc && coef_wr_addr == AW'(k)) shadow[k] <= coef_wr_data;
            end
        end
    end

    // The swap is taken on the strobe's sampling edge, so the datapath sees the new
    // set from the following strobe onward; FLUSH strobes later y is clean again.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            active    <= '0;
            out_valid <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (commit) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (sys_clk2_en) begin
                        active    <= shadow;
                        out_valid <= 1'b0;
                        swap_done <= 1'b1;
                        flush_cnt <= '0;
                        state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (sys_clk2_en) begin
                        if (flush_cnt == FW'(FLUSH - 1)) begin
                            out_valid <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            flush_cnt <= flush_cnt + FW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: strobe timing, write/commit/swap/flush sequencing,
// bad-address writes, write+commit collision and reset during flush.
module tb_fir_coeff_ctrl;

    localparam int WIDTH    = 18;
    localparam int NUM_COEF = 8;
    localparam int AW       = 4;
    localparam int BW       = NUM_COEF * WIDTH;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              coef_wr_valid;
    logic              coef_wr_ready;
    logic [AW-1:0]     coef_wr_addr;
    logic [WIDTH-1:0]  coef_wr_data;
    logic              commit;
    logic              sys_clk2_en;
    logic [BW-1:0]     coef_bus;
    logic              out_valid;
    logic              busy;
    logic              swap_done;
    logic              wr_err;

    int checks = 0;
    int errors = 0;
    int e = 0;  // rising edges since reset release

    logic signed [WIDTH-1:0] set1 [NUM_COEF] = '{-18'sd348, 18'sd0, 18'sd3274, 18'sd0,
                                                  -18'sd15925, 18'sd0, 18'sd78535, 18'sd131071};
    logic [BW-1:0] exp1;
    logic [BW-1:0] exp2;

    fir_coeff_ctrl #(.WIDTH(WIDTH), .NUM_COEF(NUM_COEF), .AW(AW), .CLK_DIV(4), .FLUSH(4)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .coef_wr_valid(coef_wr_valid), .coef_wr_ready(coef_wr_ready),
        .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .commit(commit), .sys_clk2_en(sys_clk2_en), .coef_bus(coef_bus),
        .out_valid(out_valid), .busy(busy), .swap_done(swap_done), .wr_err(wr_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, e, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            e++;
        end
    endtask

    task automatic run_to(input int target);
        while (e < target) step(1);
    endtask

    initial begin
        for (int k = 0; k < NUM_COEF; k++) exp1[k*WIDTH +: WIDTH] = set1[k];
        exp2 = exp1;
        exp2[2*WIDTH +: WIDTH] = 18'h3FFF9;  // -7

        reset = 1'b0; coef_wr_valid = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; commit = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_bus", coef_bus, '0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", coef_wr_ready, 1);
        chk("rst_strobe", sys_clk2_en, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_wr_err", wr_err, 0);

        @(negedge sys_clk);
        reset = 1'b1;
        e = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk("strobe_phase", sys_clk2_en, (e % 4 == 0) ? 1 : 0);
        end

        // load the shadow bank, edges 13..20
        for (int k = 0; k < NUM_COEF; k++) begin
            coef_wr_valid = 1'b1; coef_wr_addr = AW'(k); coef_wr_data = set1[k];
            step(1);
        end
        coef_wr_valid = 1'b0;
        chk("bus_before_commit", coef_bus, '0);
        step(1);                       // e=21, non-strobe
        commit = 1'b1;
        step(1);                       // e=22, ARMED
        commit = 1'b0;
        chk("armed_busy", busy, 1);
        chk("armed_ready", coef_wr_ready, 0);
        run_to(24);
        chk("strobe_before_swap", sys_clk2_en, 1);
        chk("bus_pre_swap", coef_bus, '0);
        step(1);                       // e=25, swap edge
        chk("bus_swapped", coef_bus, exp1);
        chk("swap_done_pulse", swap_done, 1);
        chk("out_valid_flushing", out_valid, 0);
        step(1);
        chk("swap_done_one_cycle", swap_done, 0);
        run_to(40);
        chk("out_valid_before_4th", out_valid, 0);
        step(1);                       // e=41
        chk("out_valid_after_flush", out_valid, 1);
        chk("idle_after_flush", busy, 0);

        // commit during a strobe cycle: swap a full period later
        run_to(44);
        chk("strobe_at_44", sys_clk2_en, 1);
        commit = 1'b1;
        step(1);                       // e=45, ARMED
        commit = 1'b0;
        coef_wr_valid = 1'b1; coef_wr_addr = 4'd0; coef_wr_data = 18'd5;
        chk("ready_low_armed", coef_wr_ready, 0);
        run_to(48);
        chk("no_swap_same_strobe", swap_done, 0);
        chk("out_valid_held_armed", out_valid, 1);
        step(1);                       // e=49
        chk("late_swap_done", swap_done, 1);
        chk("out_valid_drops", out_valid, 0);
        run_to(53);
        chk("ready_low_flush", coef_wr_ready, 0);
        run_to(64);
        coef_wr_valid = 1'b0;
        step(1);                       // e=65
        chk("out_valid_second", out_valid, 1);

        // out-of-range write
        coef_wr_valid = 1'b1; coef_wr_addr = 4'd9; coef_wr_data = 18'd5;
        step(1);                       // e=66
        coef_wr_valid = 1'b0;
        chk("wr_err_pulse", wr_err, 1);
        step(1);                       // e=67
        chk("wr_err_one_cycle", wr_err, 0);
        chk("bus_after_bad_write", coef_bus, exp1);
        commit = 1'b1;
        step(1);                       // e=68, ARMED in strobe cycle
        commit = 1'b0;
        step(1);                       // e=69
        chk("swap3_done", swap_done, 1);
        chk("shadow_unchanged", coef_bus, exp1);
        run_to(85);
        chk("out_valid_third", out_valid, 1);

        // write and commit in the same cycle
        coef_wr_valid = 1'b1; coef_wr_addr = 4'd2; coef_wr_data = 18'h3FFF9; commit = 1'b1;
        step(1);                       // e=86
        coef_wr_valid = 1'b0; commit = 1'b0;
        run_to(89);
        chk("wr_commit_bus", coef_bus, exp2);
        chk("wr_commit_coef2", coef_bus[2*WIDTH +: WIDTH], 18'h3FFF9);

        // reset two strobes into flush
        run_to(98);
        chk("flushing_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_bus", coef_bus, '0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_strobe", sys_clk2_en, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;
        e = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("strobe_restart", sys_clk2_en, (e % 4 == 0) ? 1 : 0);
        end
        step(1);                       // e=9
        commit = 1'b1;
        step(1);                       // e=10
        commit = 1'b0;
        run_to(13);
        chk("lost_shadow_swap", swap_done, 1);
        chk("lost_shadow_bus", coef_bus, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Coefficient and sequencing controller for the 18-bit symmetric folded FIR datapath. It generates the datapath's sys_clk2_en strobe and holds a host-writable shadow coefficient bank. On commit, it swaps the shadow bank into the active bank, aligned to a strobe boundary. It then flags the filter output invalid until the datapath pipeline has flushed.

Parameters:
WIDTH, 18, coefficient width, 0s18 signed format
NUM_COEF, 8, coefficients per bank (folded taps plus centre tap)
AW, 4, write address width; must satisfy 2^AW > NUM_COEF so out-of-range addresses are detectable
CLK_DIV, 4, sys_clk cycles per sys_clk2_en strobe (>=2)
FLUSH, 4, datapath pipeline depth in strobes (x, sum_lvl_1, sum_lvl_2..4, y)

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
coef_wr_valid  in  1  host write request
coef_wr_ready  out  1  controller can accept a write this cycle
coef_wr_addr  in  AW  coefficient index
coef_wr_data  in  WIDTH  coefficient value, 0s18
commit  in  1  single-cycle request to activate the shadow bank
sys_clk2_en  out  1  datapath sample strobe
coef_bus  out  NUM_COEF*WIDTH  active bank; coefficient k at bits [k*WIDTH +: WIDTH]
out_valid  out  1  datapath y is produced by a single, settled coefficient set
busy  out  1  state != IDLE
swap_done  out  1  one-cycle pulse after the bank swap
wr_err  out  1  one-cycle pulse on an accepted write with addr >= NUM_COEF

Behaviour:
- Reset (reset=0, asynchronous):
  - divider counter = 0; sys_clk2_en = 0.
  - Shadow and active banks all 0; coef_bus = 0.
  - State = IDLE; out_valid = 0; swap_done = 0; wr_err = 0.
- Strobe generator: free-running counter 0..CLK_DIV-1.
  - sys_clk2_en is registered and high for exactly one cycle when the counter wraps.
  - First strobe occurs in cycle CLK_DIV after reset deasserts, then every CLK_DIV cycles.
  - No other state affects the strobe.
- Write handshake:
  - A write is accepted when coef_wr_valid && coef_wr_ready.
  - An accepted write updates shadow[addr] at that edge.
  - If addr >= NUM_COEF, no register is written and wr_err pulses in the next cycle.
  - coef_wr_ready = 1 only in IDLE.
  - The active bank is never written directly.
- States:
  - IDLE: writes accepted. commit=1 -> ARMED.
    - Write and commit in the same cycle: the write lands first, and the commit uses the updated shadow.
  - ARMED: writes refused; commit ignored.
    - On the first cycle with sys_clk2_en=1 after entry: active <= shadow, out_valid <= 0, go to FLUSH with flush counter = 0.
    - If commit occurs during a strobe cycle in IDLE, the swap happens at the next strobe, not the same one.
  - FLUSH: writes refused; commit ignored.
    - Each strobe increments the flush counter.
    - On the strobe where the counter reaches FLUSH-1: out_valid <= 1, go to IDLE.
- swap_done: registered pulse, high in the cycle after the swap edge.
- Timing: the swap edge coincides with the datapath's sampling edge of that strobe. New coefficients therefore first affect mult_out on the following strobe.
- After reset, out_valid stays 0 until the first commit/flush completes.
- Reset mid-FLUSH or mid-ARMED:
  - Everything returns to reset values; the shadow contents are lost.
  - A swap and a reset on the same edge: reset wins.
- Arithmetic: none; pure storage and sequencing. Coefficients pass through unmodified (no saturation or sign extension).

Test Plan:
- Reset release, CLK_DIV=4 -> sys_clk2_en high in cycles 4, 8, 12…; coef_bus=0; out_valid=0; busy=0; coef_wr_ready=1.
- Write shadow with {-348, 0, 3274, 0, -15925, 0, 78535, 131071}, then commit in a non-strobe cycle -> coef_bus unchanged until the next strobe edge, then equals the written set. swap_done pulses in the following cycle. out_valid is 0 for 4 strobes and rises at the 4th strobe after the swap.
- Commit asserted in a strobe cycle -> swap occurs one full strobe period later. Writes during ARMED/FLUSH see coef_wr_ready=0 and leave the shadow unchanged.
- Write addr=9 with data 5 -> wr_err pulses once; shadow and coef_bus unchanged; a later commit produces the previous set.
- Write addr=2 data=-7 together with commit in the same cycle -> after the swap, coef_bus[2] = -7.
- Assert reset two strobes into FLUSH -> coef_bus=0 and out_valid=0 immediately. The strobe restarts, first occurring CLK_DIV cycles after release.
